// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer
//
// Pulls words from a single-clock FIFO read port and shifts them out MSB-first
// as a serial bit stream, one bit every CLKS_PER_BIT clocks. During the last
// bit period of a word the next word is prefetched into a holding register, so
// back-to-back words stream without a gap. enable and fifo_empty are only
// looked at when a fetch decision is taken (in IDLE, or on the first cycle of
// the last bit).
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   permits new FIFO fetches
//   fifo_empty   in   FIFO empty flag
//   fifo_data    in   FIFO read data, valid the cycle after fifo_read_en
//   fifo_read_en out  single-cycle FIFO read pulse
//   tx_bit       out  serial data, MSB first, 0 outside SHIFT
//   tx_strobe    out  first cycle of every bit period
//   tx_active    out  high in FETCH, LOAD and SHIFT
//   word_done    out  last cycle of a word's last bit
//   words_sent   out  completed-word count, wraps 255 -> 0
module fifo_drain_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx_bit,
    output logic                  tx_strobe,
    output logic                  tx_active,
    output logic                  word_done,
    output logic [7:0]            words_sent
);

    localparam int BIT_CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DIV_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(DATA_WIDTH - 1);
    localparam logic [DIV_CW-1:0] LAST_DIV = DIV_CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_SHIFT = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DIV_CW-1:0]     div_cnt_q, div_cnt_d;
    logic                  pf_pending_q, pf_pending_d;
    logic                  pf_valid_q, pf_valid_d;
    logic [7:0]            words_sent_q, words_sent_d;

    logic last_bit;
    logic last_div;
    logic word_end;

    assign words_sent = words_sent_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        pf_pending_d = pf_pending_q;
        pf_valid_d   = pf_valid_q;
        words_sent_d = words_sent_q;

        fifo_read_en = 1'b0;
        tx_bit       = 1'b0;
        tx_strobe    = 1'b0;
        word_done    = 1'b0;
        tx_active    = (state_q != S_IDLE);

        last_bit = (bit_cnt_q == LAST_BIT);
        last_div = (div_cnt_q == LAST_DIV);
        word_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                fifo_read_en = 1'b1;
                state_d      = S_LOAD;
            end

            S_LOAD: begin
                shift_d   = fifo_data;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = S_SHIFT;
            end

            default: begin  // S_SHIFT
                tx_bit    = shift_q[DATA_WIDTH-1];
                tx_strobe = (div_cnt_q == '0);
                word_end  = last_bit && last_div;

                if (last_div) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_CW'(1);
                end

                // Only decision point inside a word: first cycle of the last bit.
                if (last_bit && (div_cnt_q == '0) && enable && !fifo_empty) begin
                    fifo_read_en = 1'b1;
                    pf_pending_d = 1'b1;
                end

                if (pf_pending_q) begin
                    hold_d       = fifo_data;
                    pf_valid_d   = 1'b1;
                    pf_pending_d = 1'b0;
                end

                if (word_end) begin
                    word_done    = 1'b1;
                    words_sent_d = words_sent_q + 8'd1;
                    bit_cnt_d    = '0;
                    div_cnt_d    = '0;
                    if (pf_valid_q) begin
                        shift_d    = hold_q;
                        pf_valid_d = 1'b0;
                    end else if (pf_pending_q) begin
                        // With two clocks per bit the prefetched data arrives on
                        // the word-end cycle itself; take it straight from the FIFO.
                        shift_d      = fifo_data;
                        pf_valid_d   = 1'b0;
                        pf_pending_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            pf_pending_q <= 1'b0;
            pf_valid_q   <= 1'b0;
            words_sent_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            pf_pending_q <= pf_pending_d;
            pf_valid_q   <= pf_valid_d;
            words_sent_q <= words_sent_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: a 4-entry FIFO model feeds the design; a
// timeline model (elapsed cycles within a word) predicts every output.
module tb_fifo_drain_serializer;

    localparam int W = 8;
    localparam int C = 4;
    localparam int WORD_CYC = W * C;

    logic         clock;
    logic         reset;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_read_en;
    logic         tx_bit;
    logic         tx_strobe;
    logic         tx_active;
    logic         word_done;
    logic [7:0]   words_sent;

    fifo_drain_serializer #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .tx_bit       (tx_bit),
        .tx_strobe    (tx_strobe),
        .tx_active    (tx_active),
        .word_done    (word_done),
        .words_sent   (words_sent)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    // stimulus controls
    logic rst_drv = 1'b1;
    logic en_drv  = 1'b0;

    // FIFO contents as seen by the design, and the expected word order
    logic [W-1:0] fq[$];
    logic [W-1:0] eq[$];
    bit pop_pending = 0;
    logic prev_rd = 1'b0;

    // reference timeline model
    bit         m_shift = 0;
    int         m_lat   = 0;   // cycles remaining before shifting starts (2 = read cycle)
    int         m_t     = 0;   // elapsed cycles in current word
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_next = '0;
    bit         m_have  = 0;
    logic [7:0] m_cnt   = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        if (fq.size() < 4) begin
            fq.push_back(w);
            eq.push_back(w);
        end
    endtask

    function automatic logic [W-1:0] take_expected();
        if (eq.size() == 0) return '0;
        return eq.pop_front();
    endfunction

    task automatic cycle();
        logic e_rd, e_bit, e_stb, e_act, e_done;
        @(negedge clock);
        reset  = rst_drv;
        enable = en_drv;
        if (pop_pending) begin
            fifo_data   = (fq.size() != 0) ? fq.pop_front() : '0;
            pop_pending = 0;
        end else begin
            fifo_data = W'($urandom);
        end
        fifo_empty = (fq.size() == 0);
        #1;
        e_rd   = (m_lat == 2) ||
                 (m_shift && m_t == WORD_CYC - C && enable && !fifo_empty);
        e_bit  = m_shift ? m_word[W - 1 - m_t / C] : 1'b0;
        e_stb  = m_shift && (m_t % C == 0);
        e_act  = m_shift || (m_lat > 0);
        e_done = m_shift && (m_t == WORD_CYC - 1);
        chk("fifo_read_en", fifo_read_en, e_rd);
        chk("tx_bit", tx_bit, e_bit);
        chk("tx_strobe", tx_strobe, e_stb);
        chk("tx_active", tx_active, e_act);
        chk("word_done", word_done, e_done);
        chk("words_sent", words_sent, m_cnt);
        if (fifo_read_en) begin
            chk("read_back_to_back", prev_rd, 1'b0);
            pop_pending = 1;
        end
        prev_rd = fifo_read_en;

        if (reset) begin
            m_shift = 0; m_lat = 0; m_t = 0; m_have = 0; m_cnt = 8'd0;
            if (e_rd) void'(take_expected());
        end else if (m_shift) begin
            if (e_rd) begin
                m_next = take_expected();
                m_have = 1;
            end
            if (m_t == WORD_CYC - 1) begin
                m_cnt = m_cnt + 8'd1;
                if (m_have) begin
                    m_word = m_next;
                    m_t    = 0;
                    m_have = 0;
                end else begin
                    m_shift = 0;
                end
            end else begin
                m_t++;
            end
        end else if (m_lat == 2) begin
            m_word = take_expected();
            m_lat  = 1;
        end else if (m_lat == 1) begin
            m_lat   = 0;
            m_shift = 1;
            m_t     = 0;
        end else if (enable && !fifo_empty) begin
            m_lat = 2;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

        // reset state
        rst_drv = 1'b1;
        run(3);
        rst_drv = 1'b0;
        run(1);
        chk("reset_words_sent", words_sent, 8'd0);
        chk("reset_tx_active", tx_active, 1'b0);
        chk("reset_tx_bit", tx_bit, 1'b0);

        // single word, start latency and bit order
        push(8'hA5);
        en_drv = 1'b1;
        run(40);
        chk("single_words", words_sent, 8'd1);
        chk("single_idle", tx_active, 1'b0);

        // two words streamed back to back
        push(8'h3C); push(8'hFF);
        run(70);
        chk("gapless_words", words_sent, 8'd3);

        // FIFO empties at the prefetch point, later restart
        push(8'h81);
        run(40);
        run(5);
        push(8'h01);
        run(40);
        chk("restart_words", words_sent, 8'd5);

        // enable dropped during bit 3: word completes, nothing more fetched
        push(8'h55); push(8'hAA); push(8'h33);
        run(16);
        en_drv = 1'b0;
        run(40);
        chk("disable_words", words_sent, 8'd6);
        chk("disable_fifo_left", fq.size(), 2);

        // reset while the next word is held in the prefetch register
        push(8'h5A);
        en_drv = 1'b1;
        run(33);
        rst_drv = 1'b1;
        run(1);
        rst_drv = 1'b0;
        run(1);
        chk("midreset_words", words_sent, 8'd0);
        chk("midreset_active", tx_active, 1'b0);
        chk("midreset_bit", tx_bit, 1'b0);
        run(45);
        chk("after_reset_words", words_sent, 8'd1);
        chk("after_reset_fifo", fq.size(), 0);

        // randomized traffic, enable toggling and occasional reset
        for (int i = 0; i < 3000; i++) begin
            en_drv  = ($urandom_range(0, 9) != 0);
            rst_drv = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 2) == 0) push(W'($urandom));
            cycle();
        end
        rst_drv = 1'b0;
        en_drv  = 1'b1;
        run(200);

        // 256 words of zero: counter wraps back to 0
        rst_drv = 1'b1;
        run(2);
        rst_drv = 1'b0;
        begin
            int pushed = 0;
            for (int i = 0; i < 3 + 256 * WORD_CYC + 40; i++) begin
                if (fq.size() < 4 && pushed < 256) begin
                    push(8'h00);
                    pushed++;
                end
                cycle();
            end
        end
        chk("wrap_words", words_sent, 8'd0);
        chk("wrap_idle", tx_active, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
